// File: rtl/alu_issue_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared types and constants for the ALU issue controller slice.
//   XLEN      : default datapath width, must match the ALU.
//   alu_op_e  : 3-bit ALU operation encoding seen on cmd_op / alu_op.
//   state_e   : issue controller FSM states.
//   is_shift  : true for the ops whose operand b is a shift amount.
// Optional build macro used elsewhere in the slice: ZERO_REG_EN.
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_SLL  = 3'd2,
        ALU_SLTU = 3'd3,
        ALU_XOR  = 3'd4,
        ALU_SRL  = 3'd5,
        ALU_OR   = 3'd6,
        ALU_AND  = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    function automatic logic is_shift(alu_op_e op);
        return (op == ALU_SLL) || (op == ALU_SRL);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// ----------------------------------------------------------------------------
// alu_issue_if
// Bundles the command channel, register preload port, ALU operand/result bus
// and response channel of the ALU issue controller.
//   master : controller view (accepts commands, drives the ALU, returns result)
//   slave  : environment view (issues commands, hosts the ALU, takes results)
// Parameters: XLEN datapath width, NREGS register count (power of two).
// ----------------------------------------------------------------------------
interface alu_issue_if #(
    parameter int XLEN  = alu_pkg::XLEN,
    parameter int NREGS = 8
);
    localparam int RAW = $clog2(NREGS);

    logic            cmd_valid;
    logic            cmd_ready;
    logic [2:0]      cmd_op;
    logic [RAW-1:0]  cmd_rs1;
    logic [RAW-1:0]  cmd_rs2;
    logic [RAW-1:0]  cmd_rd;

    logic            init_we;
    logic [RAW-1:0]  init_addr;
    logic [XLEN-1:0] init_data;

    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [2:0]      alu_op;
    logic [XLEN-1:0] alu_out;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_data;
    logic [RAW-1:0]  rsp_rd;

    modport master (
        input  cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd,
        input  init_we, init_addr, init_data,
        input  alu_out, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_op,
        output rsp_valid, rsp_data, rsp_rd
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd,
        output init_we, init_addr, init_data,
        output alu_out, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_op,
        input  rsp_valid, rsp_data, rsp_rd
    );

endinterface

// File: rtl/alu_issue_ctrl_regfile.sv
// ----------------------------------------------------------------------------
// alu_regfile
// Small register file for the ALU issue controller.
//   clk, rst_n              : clock, async active-low reset (clears all regs)
//   raddr1_i/rdata1_o       : async read port for operand a
//   raddr2_i/rdata2_o       : async read port for operand b
//   wb_we_i/addr/data       : ALU result writeback port (highest priority)
//   init_we_i/addr/data     : preload port, accepted at any time
// Build macro ZERO_REG_EN: register 0 reads as zero and ignores all writes.
// ----------------------------------------------------------------------------
module alu_regfile #(
    parameter int XLEN  = alu_pkg::XLEN,
    parameter int NREGS = 8,
    parameter int RAW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [RAW-1:0]  raddr1_i,
    output logic [XLEN-1:0] rdata1_o,
    input  logic [RAW-1:0]  raddr2_i,
    output logic [XLEN-1:0] rdata2_o,
    input  logic            wb_we_i,
    input  logic [RAW-1:0]  wb_addr_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic            init_we_i,
    input  logic [RAW-1:0]  init_addr_i,
    input  logic [XLEN-1:0] init_data_i
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic            wb_en;
    logic            init_en;

    // Read ports and write qualification; register 0 is hard-wired when the
    // zero-register build is selected.
    always_comb begin
        rdata1_o = regs_q[raddr1_i];
        rdata2_o = regs_q[raddr2_i];
        wb_en    = wb_we_i;
        init_en  = init_we_i;
`ifdef ZERO_REG_EN
        if (raddr1_i == '0) rdata1_o = '0;
        if (raddr2_i == '0) rdata2_o = '0;
        if (wb_addr_i == '0) wb_en = 1'b0;
        if (init_addr_i == '0) init_en = 1'b0;
`else
`endif
    end

    // The writeback assignment comes last so it wins a same-address collision
    // with a preload in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (init_en) regs_q[init_addr_i] <= init_data_i;
            if (wb_en)   regs_q[wb_addr_i]   <= wb_data_i;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ----------------------------------------------------------------------------
// alu_issue_ctrl
// Issues register-addressed commands to a combinational ALU one at a time:
// IDLE accepts a command and latches operands, EXEC holds the ALU inputs for a
// full cycle and writes the result back, RESP presents the result until taken.
//   clk, rst_n : clock, async active-low reset (drops any in-flight command)
//   bus        : alu_issue_if.master (command, preload, ALU, response signals)
// Build macro ZERO_REG_EN: handled inside alu_regfile (register 0 reads zero).
// ----------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int XLEN  = alu_pkg::XLEN,
    parameter int NREGS = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_issue_if.master  bus
);
    import alu_pkg::*;

    localparam int RAW = $clog2(NREGS);
    localparam int SHW = $clog2(XLEN);

    state_e          state_q, state_d;
    alu_op_e         op_q;
    logic [RAW-1:0]  rd_q;
    logic [XLEN-1:0] alu_a_q, alu_b_q;
    logic [XLEN-1:0] rsp_data_q;
    logic [RAW-1:0]  rsp_rd_q;
    logic            rsp_valid_q;

    alu_op_e         cmd_op;
    logic [XLEN-1:0] rdata1, rdata2, b_operand;
    logic            cmd_ready;
    logic            cmd_fire;
    logic            wb_we;

    assign cmd_op   = alu_op_e'(bus.cmd_op);
    assign cmd_fire = bus.cmd_valid && cmd_ready;
    assign wb_we    = (state_q == S_EXEC);

    alu_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .RAW   (RAW)
    ) u_regfile (
        .clk         (clk),
        .rst_n       (rst_n),
        .raddr1_i    (bus.cmd_rs1),
        .rdata1_o    (rdata1),
        .raddr2_i    (bus.cmd_rs2),
        .rdata2_o    (rdata2),
        .wb_we_i     (wb_we),
        .wb_addr_i   (rd_q),
        .wb_data_i   (bus.alu_out),
        .init_we_i   (bus.init_we),
        .init_addr_i (bus.init_addr),
        .init_data_i (bus.init_data)
    );

    // Shift ops use only the low bits of operand b, so the amount wraps mod XLEN.
    always_comb begin
        b_operand = rdata2;
        if (is_shift(cmd_op)) begin
            b_operand = {{(XLEN-SHW){1'b0}}, rdata2[SHW-1:0]};
        end
    end

    // Next-state logic; cmd_ready depends on the state register only.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (bus.cmd_valid) state_d = S_EXEC;
            end
            S_EXEC: state_d = S_RESP;
            S_RESP: if (bus.rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Operand latch at acceptance, result capture at the end of EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= ALU_ADD;
            rd_q        <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            rsp_data_q  <= '0;
            rsp_rd_q    <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            if (cmd_fire) begin
                op_q    <= cmd_op;
                rd_q    <= bus.cmd_rd;
                alu_a_q <= rdata1;
                alu_b_q <= b_operand;
            end
            if (state_q == S_EXEC) begin
                rsp_data_q  <= bus.alu_out;
                rsp_rd_q    <= rd_q;
                rsp_valid_q <= 1'b1;
            end else if (state_q == S_RESP && bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_op    = op_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_rd    = rsp_rd_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: hosts a behavioural ALU, keeps an abstract
// register-file model, and drives table vectors, corner sequences and random
// commands. Honours the ZERO_REG_EN build macro in its model.
module tb_alu_issue_ctrl;

    localparam int NREGS = 8;

    typedef struct {
        logic [2:0]  op;
        int          rs1;
        int          rs2;
        int          rd;
        logic [31:0] aVal;
        logic [31:0] bVal;
        logic [31:0] expData;
    } vector_t;

    logic clk;
    logic rst_n;
    int   checkCount;
    int   errorCount;
    logic [31:0] modelRegs [NREGS];

    alu_issue_if #(.XLEN(32), .NREGS(NREGS)) bus ();

    alu_issue_ctrl #(.XLEN(32), .NREGS(NREGS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Expected ALU behaviour straight from the op-code table.
    function automatic logic [31:0] modelAlu(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        int unsigned amount;
        amount = b % 32;
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a << amount;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return a >> amount;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    // The ALU sitting on the far side of the bus.
    assign bus.alu_out = modelAlu(bus.alu_op, bus.alu_a, bus.alu_b);

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] modelRead(int addr);
`ifdef ZERO_REG_EN
        if (addr == 0) return 32'd0;
`endif
        return modelRegs[addr];
    endfunction

    function automatic void modelWrite(int addr, logic [31:0] data);
`ifdef ZERO_REG_EN
        if (addr == 0) return;
`endif
        modelRegs[addr] = data;
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < NREGS; i++) modelRegs[i] = 32'd0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic preloadReg(input int addr, input logic [31:0] data);
        @(negedge clk);
        bus.init_we   = 1'b1;
        bus.init_addr = 3'(addr);
        bus.init_data = data;
        @(negedge clk);
        bus.init_we   = 1'b0;
        modelWrite(addr, data);
    endtask

    // One full command: accept, EXEC checks, response checks, optional stall
    // with a competing command, optional preload during EXEC.
    task automatic applyStimulus(input logic [2:0] op, input int rs1, input int rs2, input int rd,
                                 input logic [31:0] expData, input int hold,
                                 input bit execInit, input int initAddr, input logic [31:0] initData);
        logic [31:0] expA, expB;
        int waitCnt;
        expA = modelRead(rs1);
        expB = modelRead(rs2);
        if (op == 3'd2 || op == 3'd5) expB = expB % 32;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_rs1   = 3'(rs1);
        bus.cmd_rs2   = 3'(rs2);
        bus.cmd_rd    = 3'(rd);
        bus.rsp_ready = (hold == 0);
        waitCnt = 0;
        while (bus.cmd_ready !== 1'b1 && waitCnt < 16) begin
            @(negedge clk);
            waitCnt++;
        end
        if (waitCnt >= 16) begin
            checkOutput("cmdAcceptTimeout", 32'(bus.cmd_ready), 32'd1);
            bus.cmd_valid = 1'b0;
            return;
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        checkOutput("execCmdReady", 32'(bus.cmd_ready), 32'd0);
        checkOutput("execRspValid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("execAluOp", 32'(bus.alu_op), 32'(op));
        checkOutput("execAluA", bus.alu_a, expA);
        checkOutput("execAluB", bus.alu_b, expB);
        if (execInit) begin
            bus.init_we   = 1'b1;
            bus.init_addr = 3'(initAddr);
            bus.init_data = initData;
        end
        @(negedge clk);
        bus.init_we = 1'b0;
        if (execInit) modelWrite(initAddr, initData);
        modelWrite(rd, expData);
        checkOutput("rspValid", 32'(bus.rsp_valid), 32'd1);
        checkOutput("rspData", bus.rsp_data, expData);
        checkOutput("rspRd", 32'(bus.rsp_rd), 32'(rd));
        for (int h = 0; h < hold; h++) begin
            if (h == 0) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_op    = 3'd0;
                bus.cmd_rd    = 3'd7;
            end
            @(negedge clk);
            checkOutput("stallRspValid", 32'(bus.rsp_valid), 32'd1);
            checkOutput("stallRspData", bus.rsp_data, expData);
            checkOutput("stallRspRd", 32'(bus.rsp_rd), 32'(rd));
            checkOutput("stallCmdReady", 32'(bus.cmd_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("postRspValid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("postCmdReady", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b0;
    endtask

    vector_t vectors [11];
    logic [31:0] zeroExp;

    initial begin
        checkCount = 0;
        errorCount = 0;
        clk = 1'b0;
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_rs1   = 3'd0;
        bus.cmd_rs2   = 3'd0;
        bus.cmd_rd    = 3'd0;
        bus.init_we   = 1'b0;
        bus.init_addr = 3'd0;
        bus.init_data = 32'd0;
        bus.rsp_ready = 1'b1;
        modelReset();

        vectors[0]  = '{3'd0, 1, 2, 4, 32'd5,        32'd3,        32'd8};
        vectors[1]  = '{3'd1, 1, 2, 3, 32'd3,        32'd5,        32'hFFFF_FFFE};
        vectors[2]  = '{3'd3, 1, 2, 5, 32'd3,        32'd5,        32'd1};
        vectors[3]  = '{3'd3, 1, 2, 5, 32'd5,        32'd3,        32'd0};
        vectors[4]  = '{3'd2, 1, 2, 6, 32'd1,        32'h24,       32'h10};
        vectors[5]  = '{3'd5, 1, 2, 7, 32'h8000_0000, 32'd31,      32'd1};
        vectors[6]  = '{3'd4, 1, 2, 3, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00};
        vectors[7]  = '{3'd6, 1, 2, 4, 32'h00FF_0000, 32'h0000_00FF, 32'h00FF_00FF};
        vectors[8]  = '{3'd7, 1, 2, 5, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_0000};
        vectors[9]  = '{3'd0, 1, 2, 6, 32'hFFFF_FFFF, 32'd2,       32'd1};
        vectors[10] = '{3'd5, 1, 2, 7, 32'h8000_0000, 32'h21,      32'h4000_0000};

        // Reset values while rst_n is held low.
        #12;
        checkOutput("resetRspValid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("resetRspData", bus.rsp_data, 32'd0);
        checkOutput("resetRspRd", 32'(bus.rsp_rd), 32'd0);
        checkOutput("resetAluA", bus.alu_a, 32'd0);
        checkOutput("resetAluB", bus.alu_b, 32'd0);
        checkOutput("resetAluOp", 32'(bus.alu_op), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("resetCmdReady", 32'(bus.cmd_ready), 32'd1);

        // add then xor of the result with itself.
        preloadReg(1, 32'd5);
        preloadReg(2, 32'd3);
        applyStimulus(3'd0, 1, 2, 4, 32'd8, 0, 1'b0, 0, 32'd0);
        applyStimulus(3'd4, 4, 4, 5, 32'd0, 0, 1'b0, 0, 32'd0);

        // Table vectors.
        for (int i = 0; i < 11; i++) begin
            preloadReg(vectors[i].rs1, vectors[i].aVal);
            preloadReg(vectors[i].rs2, vectors[i].bVal);
            applyStimulus(vectors[i].op, vectors[i].rs1, vectors[i].rs2, vectors[i].rd,
                          vectors[i].expData, 0, 1'b0, 0, 32'd0);
        end

        // Response stall of five cycles with a competing command waiting.
        preloadReg(1, 32'h11);
        preloadReg(2, 32'h22);
        applyStimulus(3'd6, 1, 2, 6, 32'h33, 5, 1'b0, 0, 32'd0);

        // Preload colliding with writeback: writeback must win.
        preloadReg(1, 32'd7);
        preloadReg(2, 32'd8);
        applyStimulus(3'd0, 1, 2, 3, 32'd15, 0, 1'b1, 3, 32'hDEAD_BEEF);
        applyStimulus(3'd6, 3, 3, 4, 32'd15, 0, 1'b0, 0, 32'd0);

        // Preload of a source during EXEC must not disturb latched operands.
        applyStimulus(3'd1, 1, 2, 5, 32'hFFFF_FFFF, 0, 1'b1, 1, 32'h100);
        applyStimulus(3'd0, 1, 2, 6, 32'h108, 0, 1'b0, 0, 32'd0);

        // Register 0 behaviour depends on the build.
`ifdef ZERO_REG_EN
        zeroExp = 32'd0;
`else
        zeroExp = 32'd14;
`endif
        preloadReg(0, 32'd7);
        applyStimulus(3'd0, 0, 0, 0, zeroExp, 0, 1'b0, 0, 32'd0);
        applyStimulus(3'd6, 0, 0, 1, zeroExp, 0, 1'b0, 0, 32'd0);

        // Reset during EXEC drops the command and clears the registers.
        preloadReg(1, 32'd10);
        preloadReg(2, 32'd20);
        @(negedge clk);
        checkOutput("rstPreCmdReady", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd0;
        bus.cmd_rs1   = 3'd1;
        bus.cmd_rs2   = 3'd2;
        bus.cmd_rd    = 3'd5;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        checkOutput("rstExecCmdReady", 32'(bus.cmd_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("rstRspValid", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        checkOutput("rstHeldRspValid", 32'(bus.rsp_valid), 32'd0);
        rst_n = 1'b1;
        modelReset();
        @(negedge clk);
        checkOutput("rstRelCmdReady", 32'(bus.cmd_ready), 32'd1);
        checkOutput("rstRelRspValid", 32'(bus.rsp_valid), 32'd0);
        applyStimulus(3'd6, 5, 5, 6, 32'd0, 0, 1'b0, 0, 32'd0);
        applyStimulus(3'd0, 1, 2, 7, 32'd0, 0, 1'b0, 0, 32'd0);

        // Random commands against the register-file model.
        for (int i = 0; i < 60; i++) begin
            logic [2:0] rop;
            int rs1, rs2, rd, hold, initAddr;
            bit execInit;
            logic [31:0] initData, expData;
            if ($urandom_range(0, 1) == 1) preloadReg($urandom_range(0, NREGS-1), $urandom);
            if ($urandom_range(0, 1) == 1) preloadReg($urandom_range(0, NREGS-1), $urandom);
            rop      = 3'($urandom_range(0, 7));
            rs1      = $urandom_range(0, NREGS-1);
            rs2      = $urandom_range(0, NREGS-1);
            rd       = $urandom_range(0, NREGS-1);
            hold     = $urandom_range(0, 2);
            execInit = ($urandom_range(0, 3) == 0);
            initAddr = $urandom_range(0, NREGS-1);
            initData = $urandom;
            expData  = modelAlu(rop, modelRead(rs1), modelRead(rs2));
            applyStimulus(rop, rs1, rs2, rd, expData, hold, execInit, initAddr, initData);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
